// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals around
// mem_port_arbiter. The arbiter takes the slave view; the pipeline/memory
// environment takes the master view.
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        dm_req_valid;
  logic [3:0]  dm_req_wmask;
  logic [31:0] dm_req_addr;
  logic [31:0] dm_req_wdata;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  logic        busy;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_valid, dm_req_wmask, dm_req_addr, dm_req_wdata,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data,
    output mem_req_valid, mem_req_wmask, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output busy
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_valid, dm_req_wmask, dm_req_addr, dm_req_wdata,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
    input  mem_req_valid, mem_req_wmask, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: data-priority arbitration between fetch and
// data access with an anti-starvation counter, one registered request slot
// and an in-order tag FIFO routing read responses back to their source.
// Optional macro MEM_ARB_PERF_CNT_EN adds conflict/stall performance counters.
module mem_port_arbiter #(
  parameter int unsigned MAX_OUT    = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_conflict_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);
  localparam int unsigned CW = $clog2(MAX_OUT) + 1;
  localparam int unsigned PW = $clog2(MAX_OUT);
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic               src_q, src_d;          // 0 = fetch, 1 = data
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [MAX_OUT-1:0] fifo_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      starve_q, starve_d;

  logic          slot_rd, push, pop, head, can_accept, rd_room, starve_full;
  logic          if_cand, dm_cand, grant_if, grant_dm, if_acc, dm_acc;
  logic [CW:0]   occ;

  assign slot_rd     = (state_q == ST_FULL) && (wmask_q == '0);
  assign push        = slot_rd && bus.mem_req_ready;
  assign pop         = bus.mem_rsp_valid && (cnt_q != '0);
  assign head        = fifo_q[rd_ptr_q];
  assign can_accept  = (state_q == ST_EMPTY) || bus.mem_req_ready;
  assign starve_full = (starve_q == SW'(STARVE_MAX));

  // Reads already in the slot count against the limit; a response popping
  // this cycle frees its entry for an accept in the same cycle.
  assign occ     = {1'b0, cnt_q} + {{CW{1'b0}}, slot_rd} - {{CW{1'b0}}, pop};
  assign rd_room = occ < (CW+1)'(MAX_OUT);

  // Arbitration: forced fetch when starved, else data first; a requester
  // blocked by the outstanding-read limit forfeits to the other one.
  always_comb begin
    if_cand  = bus.if_req_valid && rd_room;
    dm_cand  = bus.dm_req_valid && (rd_room || (bus.dm_req_wmask != '0));
    grant_if = if_cand && ((starve_full && bus.if_req_valid) || !dm_cand);
    grant_dm = dm_cand && !grant_if;
  end

  assign if_acc = grant_if && can_accept && rst_n;
  assign dm_acc = grant_dm && can_accept && rst_n;

  assign bus.if_req_ready  = if_acc;
  assign bus.dm_req_ready  = dm_acc;
  assign bus.mem_req_valid = (state_q == ST_FULL);
  assign bus.mem_req_wmask = wmask_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.if_rsp_valid  = pop && !head;
  assign bus.dm_rsp_valid  = pop && head;
  assign bus.if_rsp_data   = (pop && !head) ? bus.mem_rsp_data : '0;
  assign bus.dm_rsp_data   = (pop && head)  ? bus.mem_rsp_data : '0;
  assign bus.busy          = (state_q == ST_FULL) || (cnt_q != '0);

  // Request slot: load on accept (also while draining), clear when drained.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (if_acc) begin
      state_d = ST_FULL;
      src_d   = 1'b0;
      wmask_d = '0;
      addr_d  = bus.if_req_addr;
      wdata_d = '0;
    end else if (dm_acc) begin
      state_d = ST_FULL;
      src_d   = 1'b1;
      wmask_d = bus.dm_req_wmask;
      addr_d  = bus.dm_req_addr;
      wdata_d = bus.dm_req_wdata;
    end else if ((state_q == ST_FULL) && bus.mem_req_ready) begin
      state_d = ST_EMPTY;
      src_d   = 1'b0;
      wmask_d = '0;
      addr_d  = '0;
      wdata_d = '0;
    end
  end

  // Tag FIFO occupancy and starvation counter next-state.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    starve_d = starve_q;
    if (!bus.if_req_valid || if_acc) starve_d = '0;
    else if (dm_acc && !starve_full) starve_d = starve_q + SW'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      src_q    <= 1'b0;
      wmask_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      wmask_q  <= wmask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= src_q;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Performance counters: both requesters valid, and any valid requester stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (bus.if_req_valid && bus.dm_req_valid)
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if ((bus.if_req_valid && !if_acc) || (bus.dm_req_valid && !dm_acc))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic done = 1'b0;

  mem_port_arbiter_if bus();

  logic        auto_mode, auto_v, man_v;
  logic [31:0] auto_d, man_d;
  assign bus.mem_rsp_valid = auto_mode ? auto_v : man_v;
  assign bus.mem_rsp_data  = auto_mode ? auto_d : man_d;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_cnt, perf_stall_cnt;
`endif

  mem_port_arbiter #(.MAX_OUT(4), .STARVE_MAX(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: answers each read leaving the slot one cycle later with ~addr.
  initial begin : responder
    logic        hs;
    logic [31:0] a;
    auto_v = 1'b0;
    auto_d = '0;
    forever begin
      @(negedge clk);
      hs = bus.mem_req_valid && bus.mem_req_ready && (bus.mem_req_wmask == 4'h0);
      a  = bus.mem_req_addr;
      @(posedge clk);
      #1;
      auto_v = hs;
      auto_d = ~a;
    end
  end

  initial begin : watchdog
    #200000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog expired");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_valid  = 1'b0;
    bus.if_req_addr   = '0;
    bus.dm_req_valid  = 1'b0;
    bus.dm_req_wmask  = '0;
    bus.dm_req_addr   = '0;
    bus.dm_req_wdata  = '0;
    bus.mem_req_ready = 1'b1;
    man_v = 1'b0;
    man_d = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    auto_mode = 1'b0;
    bus.if_req_valid = 1'b1;
    bus.dm_req_valid = 1'b1;
    man_v = 1'b1;
    man_d = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++; if (bus.if_req_ready !== 1'b0) $display("FAIL rst_if_ready: got %b want 0", bus.if_req_ready); else n_pass++;
    n_checks++; if (bus.dm_req_ready !== 1'b0) $display("FAIL rst_dm_ready: got %b want 0", bus.dm_req_ready); else n_pass++;
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b want 0", bus.mem_req_valid); else n_pass++;
    n_checks++; if (bus.mem_req_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", bus.mem_req_addr); else n_pass++;
    n_checks++; if (bus.if_rsp_valid !== 1'b0) $display("FAIL rst_if_rsp: got %b want 0", bus.if_rsp_valid); else n_pass++;
    n_checks++; if (bus.dm_rsp_data !== 32'h0) $display("FAIL rst_dm_data: got %h want 0", bus.dm_rsp_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h100;
    @(negedge clk);
    n_checks++; if (bus.if_req_ready !== 1'b1) $display("FAIL sr_ready: got %b want 1", bus.if_req_ready); else n_pass++;
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL sr_memv0: got %b want 0", bus.mem_req_valid); else n_pass++;
    tick();
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_req_valid !== 1'b1) $display("FAIL sr_memv1: got %b want 1", bus.mem_req_valid); else n_pass++;
    n_checks++; if (bus.mem_req_addr !== 32'h100) $display("FAIL sr_addr: got %h want 00000100", bus.mem_req_addr); else n_pass++;
    n_checks++; if (bus.mem_req_wmask !== 4'h0) $display("FAIL sr_wmask: got %h want 0", bus.mem_req_wmask); else n_pass++;
    tick();
    man_v = 1'b1;
    man_d = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (bus.if_rsp_valid !== 1'b1) $display("FAIL sr_rspv: got %b want 1", bus.if_rsp_valid); else n_pass++;
    n_checks++; if (bus.if_rsp_data !== 32'hDEAD_BEEF) $display("FAIL sr_rspd: got %h want deadbeef", bus.if_rsp_data); else n_pass++;
    n_checks++; if (bus.dm_rsp_valid !== 1'b0) $display("FAIL sr_dm_rspv: got %b want 0", bus.dm_rsp_valid); else n_pass++;
    tick();
    man_v = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.if_rsp_valid !== 1'b0) $display("FAIL sr_pulse: got %b want 0", bus.if_rsp_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL sr_busy: got %b want 0", bus.busy); else n_pass++;
    tick();
  endtask

  task automatic test_store_then_fetch();
    bus.dm_req_valid = 1'b1;
    bus.dm_req_wmask = 4'hF;
    bus.dm_req_addr  = 32'h200;
    bus.dm_req_wdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if (bus.dm_req_ready !== 1'b1) $display("FAIL st_ready: got %b want 1", bus.dm_req_ready); else n_pass++;
    tick();
    bus.dm_req_valid = 1'b0;
    bus.dm_req_wmask = 4'h0;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h300;
    @(negedge clk);
    n_checks++; if (bus.mem_req_wmask !== 4'hF) $display("FAIL st_wmask: got %h want f", bus.mem_req_wmask); else n_pass++;
    n_checks++; if (bus.mem_req_addr !== 32'h200) $display("FAIL st_addr: got %h want 00000200", bus.mem_req_addr); else n_pass++;
    n_checks++; if (bus.mem_req_wdata !== 32'h1234_5678) $display("FAIL st_wdata: got %h want 12345678", bus.mem_req_wdata); else n_pass++;
    n_checks++; if (bus.if_req_ready !== 1'b1) $display("FAIL st_if_b2b: got %b want 1", bus.if_req_ready); else n_pass++;
    tick();
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_req_addr !== 32'h300) $display("FAIL st_if_addr: got %h want 00000300", bus.mem_req_addr); else n_pass++;
    n_checks++; if (bus.dm_rsp_valid !== 1'b0) $display("FAIL st_no_rsp: got %b want 0", bus.dm_rsp_valid); else n_pass++;
    tick();
    man_v = 1'b1;
    man_d = 32'hCAFE_F00D;
    @(negedge clk);
    n_checks++; if (bus.if_rsp_valid !== 1'b1) $display("FAIL st_if_rspv: got %b want 1", bus.if_rsp_valid); else n_pass++;
    n_checks++; if (bus.if_rsp_data !== 32'hCAFE_F00D) $display("FAIL st_if_rspd: got %h want cafef00d", bus.if_rsp_data); else n_pass++;
    n_checks++; if (bus.dm_rsp_valid !== 1'b0) $display("FAIL st_dm_rspv: got %b want 0", bus.dm_rsp_valid); else n_pass++;
    tick();
    man_v = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL st_busy: got %b want 0", bus.busy); else n_pass++;
    tick();
  endtask

  task automatic test_starvation();
    logic [7:0]  exp_dm;
    logic [1:0]  exp_g, got_g;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] p0;
`endif
    exp_dm = 8'b0111_0111;  // bit i: grant i goes to data
    auto_mode = 1'b1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h1000;
    bus.dm_req_valid = 1'b1;
    bus.dm_req_wmask = 4'h0;
    bus.dm_req_addr  = 32'h2000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef MEM_ARB_PERF_CNT_EN
      if (i == 0) p0 = perf_conflict_cnt;
`endif
      got_g = {bus.if_req_ready, bus.dm_req_ready};
      exp_g = exp_dm[i] ? 2'b01 : 2'b10;
      n_checks++; if (got_g !== exp_g) $display("FAIL starve_grant%0d: got if/dm %b want %b", i, got_g, exp_g); else n_pass++;
      tick();
    end
    bus.if_req_valid = 1'b0;
    bus.dm_req_valid = 1'b0;
`ifdef MEM_ARB_PERF_CNT_EN
    @(negedge clk);
    n_checks++; if (perf_conflict_cnt !== p0 + 32'd8) $display("FAIL perf_conflict: got %0d want %0d", perf_conflict_cnt, p0 + 32'd8); else n_pass++;
`endif
    for (int k = 0; k < 10 && bus.busy; k++) tick();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL starve_drain: got busy %b want 0", bus.busy); else n_pass++;
    tick();
    auto_mode = 1'b0;
  endtask

  task automatic test_max_outstanding();
    logic        exp_rdy, exp_memv, exp_rspv;
    logic [31:0] exp_addr, exp_rspd;
    for (int c = 0; c < 12; c++) begin
      bus.if_req_valid = (c <= 7);
      bus.if_req_addr  = 32'h40 + 32'(4 * ((c < 4) ? c : 4));
      man_v = (c >= 7);
      man_d = 32'hA000_0000 + 32'(c - 6);
      exp_rdy  = (c < 4) || (c == 7);
      exp_memv = (c >= 1 && c <= 4) || (c == 8);
      exp_addr = 32'h40 + 32'(4 * ((c == 8) ? 4 : c - 1));
      exp_rspv = (c >= 7);
      exp_rspd = exp_rspv ? 32'hA000_0000 + 32'(c - 6) : 32'h0;
      @(negedge clk);
      if (c <= 7) begin
        n_checks++; if (bus.if_req_ready !== exp_rdy) $display("FAIL mo_ready%0d: got %b want %b", c, bus.if_req_ready, exp_rdy); else n_pass++;
      end
      n_checks++; if (bus.mem_req_valid !== exp_memv) $display("FAIL mo_memv%0d: got %b want %b", c, bus.mem_req_valid, exp_memv); else n_pass++;
      if (exp_memv) begin
        n_checks++; if (bus.mem_req_addr !== exp_addr) $display("FAIL mo_addr%0d: got %h want %h", c, bus.mem_req_addr, exp_addr); else n_pass++;
      end
      n_checks++; if (bus.if_rsp_valid !== exp_rspv) $display("FAIL mo_rspv%0d: got %b want %b", c, bus.if_rsp_valid, exp_rspv); else n_pass++;
      n_checks++; if (bus.if_rsp_data !== exp_rspd) $display("FAIL mo_rspd%0d: got %h want %h", c, bus.if_rsp_data, exp_rspd); else n_pass++;
      n_checks++; if (bus.dm_rsp_valid !== 1'b0) $display("FAIL mo_dm_rspv%0d: got %b want 0", c, bus.dm_rsp_valid); else n_pass++;
      tick();
    end
    man_v = 1'b0;
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mo_busy: got %b want 0", bus.busy); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    auto_mode = 1'b1;
    bus.mem_req_ready = 1'b0;
    bus.dm_req_valid  = 1'b1;
    bus.dm_req_wmask  = 4'h0;
    bus.dm_req_addr   = 32'h400;
    @(negedge clk);
    n_checks++; if (bus.dm_req_ready !== 1'b1) $display("FAIL bp_first: got %b want 1", bus.dm_req_ready); else n_pass++;
    tick();
    bus.dm_req_addr  = 32'h404;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h500;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++; if ({bus.if_req_ready, bus.dm_req_ready} !== 2'b00) $display("FAIL bp_ready%0d: got %b want 00", c, {bus.if_req_ready, bus.dm_req_ready}); else n_pass++;
      n_checks++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 32'h400}) $display("FAIL bp_hold%0d: got %b/%h want 1/00000400", c, bus.mem_req_valid, bus.mem_req_addr); else n_pass++;
      tick();
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus.if_req_ready, bus.dm_req_ready} !== 2'b01) $display("FAIL bp_release: got %b want 01", {bus.if_req_ready, bus.dm_req_ready}); else n_pass++;
    tick();
    bus.dm_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.if_req_ready !== 1'b1) $display("FAIL bp_if_ready: got %b want 1", bus.if_req_ready); else n_pass++;
    n_checks++; if (bus.mem_req_addr !== 32'h404) $display("FAIL bp_addr2: got %h want 00000404", bus.mem_req_addr); else n_pass++;
    n_checks++; if ({bus.dm_rsp_valid, bus.dm_rsp_data} !== {1'b1, 32'hFFFF_FBFF}) $display("FAIL bp_rsp1: got %b/%h want 1/fffffbff", bus.dm_rsp_valid, bus.dm_rsp_data); else n_pass++;
    tick();
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_req_addr !== 32'h500) $display("FAIL bp_addr3: got %h want 00000500", bus.mem_req_addr); else n_pass++;
    n_checks++; if ({bus.dm_rsp_valid, bus.dm_rsp_data} !== {1'b1, 32'hFFFF_FBFB}) $display("FAIL bp_rsp2: got %b/%h want 1/fffffbfb", bus.dm_rsp_valid, bus.dm_rsp_data); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if ({bus.if_rsp_valid, bus.if_rsp_data} !== {1'b1, 32'hFFFF_FAFF}) $display("FAIL bp_rsp3: got %b/%h want 1/fffffaff", bus.if_rsp_valid, bus.if_rsp_data); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL bp_busy: got %b want 0", bus.busy); else n_pass++;
    tick();
    auto_mode = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h600;
    tick();
    bus.if_req_addr  = 32'h604;
    tick();
    bus.if_req_addr   = 32'h608;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.busy, bus.mem_req_addr} !== {1'b1, 32'h604}) $display("FAIL ar_pre: got %b/%h want 1/00000604", bus.busy, bus.mem_req_addr); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL ar_memv: got %b want 0", bus.mem_req_valid); else n_pass++;
    n_checks++; if (bus.mem_req_addr !== 32'h0) $display("FAIL ar_addr: got %h want 0", bus.mem_req_addr); else n_pass++;
    n_checks++; if (bus.if_req_ready !== 1'b0) $display("FAIL ar_ready: got %b want 0", bus.if_req_ready); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", bus.busy); else n_pass++;
    tick();
    rst_n = 1'b1;
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      man_v = 1'b1;
      man_d = 32'h55AA_55AA;
      @(negedge clk);
      n_checks++; if ({bus.if_rsp_valid, bus.dm_rsp_valid} !== 2'b00) $display("FAIL ar_late_rsp%0d: got %b want 00", c, {bus.if_rsp_valid, bus.dm_rsp_valid}); else n_pass++;
      n_checks++; if (bus.if_rsp_data !== 32'h0) $display("FAIL ar_late_data%0d: got %h want 0", c, bus.if_rsp_data); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL ar_busy_post%0d: got %b want 0", c, bus.busy); else n_pass++;
      tick();
    end
    man_v = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_store_then_fetch();
    test_starvation();
    test_max_outstanding();
    test_back_to_back();
    test_async_reset();
    tick();
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between instruction fetch (IF) and data access (MEM stage).
- Uses data-priority arbitration with an anti-starvation counter.
- Holds one registered request slot toward memory and tracks outstanding reads in an in-order tag FIFO, so each read response returns to its originator.
- Sits between the IF/MEM stages and the BRAM/MMIO port. Its `*_req_ready` outputs feed the pipeline's stall logic alongside the forwarding/interlock unit.

Parameters:
- `MAX_OUT`, 4: maximum outstanding reads; depth of the tag FIFO; power of 2, ≥2.
- `STARVE_MAX`, 3: consecutive data grants allowed while IF is waiting before IF is forced.

Ports:
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `if_req_valid` input 1: fetch read request.
- `if_req_addr` input 32: fetch byte address.
- `if_req_ready` output 1: fetch request accepted this cycle.
- `if_rsp_valid` output 1: fetch data valid (single-cycle pulse).
- `if_rsp_data` output 32: fetch data.
- `dm_req_valid` input 1: data request.
- `dm_req_wmask` input 4: byte write mask; 0 = read.
- `dm_req_addr` input 32: data byte address.
- `dm_req_wdata` input 32: store data.
- `dm_req_ready` output 1: data request accepted this cycle.
- `dm_rsp_valid` output 1: load data valid (single-cycle pulse).
- `dm_rsp_data` output 32: load data.
- `mem_req_valid` output 1: request to memory.
- `mem_req_ready` input 1: memory accepts request.
- `mem_req_wmask` output 4.
- `mem_req_addr` output 32.
- `mem_req_wdata` output 32.
- `mem_rsp_valid` input 1: read data returned; strictly in order, reads only.
- `mem_rsp_data` input 32.
- `busy` output 1: slot occupied or FIFO non-empty.

Behaviour:
- Reset values: all ready/valid outputs 0; `mem_req_*` 0; `*_rsp_data` 0; FIFO empty; starve counter 0. Asynchronous reset is legal mid-transaction. After reset, any responses still in flight from memory are discarded, because the FIFO is empty.
- Handshake: a transfer happens on a cycle with valid & ready. Requesters may not drop or change a request until it is accepted. `*_req_ready` is combinational from inputs and state.
- Slot states:
  - EMPTY: slot free.
  - FULL: slot holds a request.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `mem_req_ready` with no new accept.
  - FULL→FULL when `mem_req_ready` and a new accept occur in the same cycle (back-to-back, one request per cycle).
- `can_accept` = slot EMPTY, or `mem_req_ready`.
- `rd_ok` = FIFO count (including reads in the slot) < `MAX_OUT`, or the candidate is a write (`wmask` ≠ 0).
- Arbitration order:
  - If the starve counter equals `STARVE_MAX` and IF is valid, IF wins.
  - Otherwise data wins over IF.
  - A candidate blocked by `rd_ok` forfeits to the other requester.
  - Only the winner sees ready = `can_accept` & `rd_ok`; the loser's ready is 0.
- Starve counter:
  - Increments, saturating at `STARVE_MAX`, on each data accept while `if_req_valid` = 1.
  - Clears on an IF accept, or on any cycle with `if_req_valid` = 0.
- Latency: an accepted request appears on `mem_req_*` the next cycle (1 cycle).
- Tag FIFO: on a read leaving the slot (`mem_req_valid` & `mem_req_ready` & `wmask` = 0), push the source bit (0 = IF, 1 = data). Writes push nothing and produce no response.
- Responses: on `mem_rsp_valid`, pop the FIFO and drive that source's `rsp_valid`/`rsp_data` combinationally in the same cycle. Push and pop in the same cycle keep the count unchanged.
- Protocol errors: `mem_rsp_valid` with an empty FIFO is ignored and `dm_rsp_valid`/`if_rsp_valid` stay 0. Bench assertion: this never happens.
- Count width: $clog2(`MAX_OUT`)+1 bits; no wrap. Pointers wrap modulo `MAX_OUT`.

Optional Feature:
- Macro: `MEM_ARB_PERF_CNT_EN`.
- When defined, adds output ports:
  - `perf_conflict_cnt` (32): increments each cycle both `if_req_valid` and `dm_req_valid` are 1.
  - `perf_stall_cnt` (32): increments each cycle a valid requester is not ready.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single IF read of addr 0x100, memory 1-cycle response 0xDEADBEEF → `mem_req_valid` at cycle+1; `if_rsp_valid` pulse with 0xDEADBEEF; `dm_rsp_valid` stays 0.
- IF and data both valid continuously, data reads, `STARVE_MAX` = 3 → grant order D,D,D,I,D,D,D,I; `perf_conflict_cnt` increments every cycle when the macro is defined.
- Data store wmask 0xF, addr 0x200, data 0x12345678, followed by an IF read → store passes with no response and nothing pushed to the FIFO; the single response goes to IF.
- `mem_rsp_valid` withheld, IF issues 5 reads with `MAX_OUT` = 4 → fifth `if_req_ready` = 0 until the first response, then accepted the same cycle; responses return to IF in order 1–5.
- `mem_req_ready` held 0 for 3 cycles with the slot FULL → `mem_req_*` stable; both readies 0; on release, a new request is accepted the same cycle (back-to-back).
- `rst_n` asserted with 2 reads outstanding → outputs 0 immediately (asynchronously); after deassert, late `mem_rsp_valid` produces no `rsp_valid`; `busy` = 0.
